// File: rtl/boot_sequencer_if.sv
// Byte-stream input handshake and instruction-memory bus of the boot sequencer.
// The slave modport is the sequencer side; master is the stream source / memory side.
interface boot_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
  );
endinterface

// File: rtl/boot_sequencer.sv
// Power-up program loader: takes a length-prefixed little-endian byte stream, writes
// each packed word to instruction memory, then hands the memory port to the PC.
module boot_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  boot_sequencer_if.slave       bus,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  on_bios,
  output logic                  pipe_enable,
  output logic [ADDR_WIDTH-1:0] words_loaded,
  output logic                  done,
  output logic                  error
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [TMO_W-1:0]      TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN   = DATA_WIDTH'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HEADER, ST_LOAD, ST_WRITE, ST_RUN, ST_ERROR
  } state_t;

  state_t                state_q,  state_d;
  logic [LANE_W-1:0]     lane_q,   lane_d;
  logic [TMO_W-1:0]      tmo_q,    tmo_d;
  logic [DATA_WIDTH-1:0] word_q,   word_d;
  logic [ADDR_WIDTH-1:0] len_q,    len_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [ADDR_WIDTH-1:0] count_q,  count_d;

  logic in_ready_q, in_ready_d;
  logic mem_cs_q,   mem_cs_d;
  logic mem_we_q,   mem_we_d;
  logic mem_oe_q,   mem_oe_d;
  logic on_bios_q,  on_bios_d;
  logic pipe_q,     pipe_d;
  logic done_q,     done_d;
  logic error_q,    error_d;

  logic xfer;
  assign xfer = bus.in_valid && in_ready_q;

  always_comb begin
    // NOTE: every signal takes its held value first, so no branch of the case can infer a latch.
    state_d = state_q;
    lane_d  = lane_q;
    tmo_d   = tmo_q;
    word_d  = word_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          state_d = ST_HEADER;
          lane_d  = '0;
          tmo_d   = '0;
        end
      end
      ST_HEADER, ST_LOAD: begin
        if (xfer) begin
          word_d[{lane_q, 3'b000} +: 8] = bus.in_data;
          tmo_d  = '0;
          lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
          if (lane_q == LAST_LANE) begin
            if (state_q == ST_HEADER) begin
              if (word_d == '0 || word_d > MAX_LEN) begin
                state_d = ST_ERROR;
              end else begin
                state_d = ST_LOAD;
                len_d   = ADDR_WIDTH'(word_d);
                count_d = '0;
              end
            end else begin
              wdata_d = word_d;
              addr_d  = BASE + count_q;
              state_d = ST_WRITE;
            end
          end
        end else begin
          // A stall partway through a word still aborts; the partial word is discarded.
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LIMIT) state_d = ST_ERROR;
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        state_d = (count_d == len_q) ? ST_RUN : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    in_ready_d = (state_d == ST_HEADER) || (state_d == ST_LOAD);
    mem_we_d   = (state_d == ST_WRITE);
    mem_oe_d   = (state_d == ST_RUN);
    mem_cs_d   = !((state_d == ST_WRITE) || (state_d == ST_RUN));
    on_bios_d  = (state_d == ST_HEADER) || (state_d == ST_LOAD) || (state_d == ST_WRITE);
    pipe_d     = (state_d == ST_RUN);
    done_d     = (state_d == ST_RUN) && (state_q != ST_RUN);
    error_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      tmo_q      <= '0;
      word_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      mem_cs_q   <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_oe_q   <= 1'b0;
      on_bios_q  <= 1'b0;
      pipe_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      lane_q     <= lane_d;
      tmo_q      <= tmo_d;
      word_q     <= word_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_oe_q   <= mem_oe_d;
      on_bios_q  <= on_bios_d;
      pipe_q     <= pipe_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // In RUN the program counter drives the instruction memory directly.
  assign bus.mem_addr  = (state_q == ST_RUN) ? pc_addr : addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_oe    = mem_oe_q;
  assign bus.in_ready  = in_ready_q;
  assign on_bios       = on_bios_q;
  assign pipe_enable   = pipe_q;
  assign words_loaded  = count_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized scoreboard bench: a 32-bit instance (short timeout) and a 16-bit instance
// whose base address sits just below 2^32 so the write addresses wrap.
module tb_boot_sequencer;

  localparam int MAX_WORDS = 256;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed {
    logic        in_ready, mem_cs, mem_we, mem_oe, on_bios, pipe, done, error;
    logic [31:0] mem_addr, mem_wdata, words;
  } obs_t;

  logic clock = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic [31:0] pc0, pc1;
  logic on_bios0, pipe0, done0, error0, on_bios1, pipe1, done1, error1;
  logic [31:0] wl0, wl1;

  boot_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if0 ();
  boot_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) if1 ();

  boot_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(0),
                   .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(16)) dut0 (
    .clock(clock), .reset(rst_n), .start(start0), .bus(if0), .pc_addr(pc0),
    .on_bios(on_bios0), .pipe_enable(pipe0), .words_loaded(wl0), .done(done0), .error(error0));

  // BASE_ADDR = -2 is 0xFFFF_FFFE at 32 bits.
  boot_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .BASE_ADDR(-2),
                   .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(1024)) dut1 (
    .clock(clock), .reset(rst_n), .start(start1), .bus(if1), .pc_addr(pc1),
    .on_bios(on_bios1), .pipe_enable(pipe1), .words_loaded(wl1), .done(done1), .error(error1));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt0 = 0, done_cnt1 = 0;
  int stall_cnt0 = 0, stall_cnt1 = 0;
  wr_t exp0[$];
  wr_t exp1[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.in_ready = if0.in_ready; o.mem_cs = if0.mem_cs; o.mem_we = if0.mem_we;
      o.mem_oe = if0.mem_oe; o.on_bios = on_bios0; o.pipe = pipe0; o.done = done0;
      o.error = error0; o.mem_addr = if0.mem_addr; o.mem_wdata = if0.mem_wdata; o.words = wl0;
    end else begin
      o.in_ready = if1.in_ready; o.mem_cs = if1.mem_cs; o.mem_we = if1.mem_we;
      o.mem_oe = if1.mem_oe; o.on_bios = on_bios1; o.pipe = pipe1; o.done = done1;
      o.error = error1; o.mem_addr = if1.mem_addr; o.mem_wdata = {16'h0, if1.mem_wdata};
      o.words = wl1;
    end
    return o;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : 32'hFFFF_FFFE;
  endfunction

  function automatic int lanes_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitors: every mem_we cycle must match the oldest expected write.
  always @(negedge clock) begin : mon0
    wr_t e;
    if (rst_n && if0.mem_we) begin
      if (exp0.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL d0_write: unexpected write addr=0x%0h data=0x%0h", if0.mem_addr, if0.mem_wdata);
      end else begin
        e = exp0.pop_front();
        check("d0_wr_addr", if0.mem_addr, e.addr);
        check("d0_wr_data", if0.mem_wdata, e.data);
        check("d0_wr_cs_oe_ready", {if0.mem_cs, if0.mem_oe, if0.in_ready}, 3'b000);
      end
    end
    if (done0) done_cnt0++;
    if (on_bios0 && !if0.in_ready) stall_cnt0++;
  end

  always @(negedge clock) begin : mon1
    wr_t e;
    if (rst_n && if1.mem_we) begin
      if (exp1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL d1_write: unexpected write addr=0x%0h data=0x%0h", if1.mem_addr, if1.mem_wdata);
      end else begin
        e = exp1.pop_front();
        check("d1_wr_addr", if1.mem_addr, e.addr);
        check("d1_wr_data", {16'h0, if1.mem_wdata}, e.data);
        check("d1_wr_cs_oe_ready", {if1.mem_cs, if1.mem_oe, if1.in_ready}, 3'b000);
      end
    end
    if (done1) done_cnt1++;
    if (on_bios1 && !if1.in_ready) stall_cnt1++;
  end

  task automatic set_in(input int d, input logic v, input logic [7:0] b);
    if (d == 0) begin if0.in_valid = v; if0.in_data = b; end
    else        begin if1.in_valid = v; if1.in_data = b; end
  endtask

  task automatic push_exp(input int d, input logic [31:0] a, input logic [31:0] v);
    wr_t e;
    e.addr = a; e.data = v;
    if (d == 0) exp0.push_back(e); else exp1.push_back(e);
  endtask

  function automatic int pending(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic pulse_start(input int d);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic add_bytes(inout bq_t b, input logic [31:0] v, input int lanes);
    for (int k = 0; k < lanes; k++) b.push_back(v[8*k +: 8]);
  endtask

  // Offers bytes in order; a byte advances only on a cycle where in_ready was high.
  task automatic stream(input int d, input bq_t b, input bit gaps);
    int i = 0;
    int guard = 0;
    bit rdy;
    bit gapped = 1'b0;
    while (i < b.size() && guard < 4000) begin
      guard++;
      if (gaps && !gapped && $urandom_range(0, 3) == 0) begin
        set_in(d, 1'b0, 8'h00); gapped = 1'b1; rdy = 1'b0;
      end else begin
        set_in(d, 1'b1, b[i]); gapped = 1'b0; rdy = obs(d).in_ready;
      end
      @(posedge clock); #1;
      if (rdy) i++;
    end
    set_in(d, 1'b0, 8'h00);
    if (i < b.size()) begin
      n_checks++; n_errors++;
      $display("FAIL stream_d%0d: sent %0d of %0d bytes before cycle budget ran out", d, i, b.size());
    end
  endtask

  task automatic wait_done(input int d, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (obs(d).done) begin n = i; break; end
    end
  endtask

  task automatic check_reset(input int d);
    obs_t o = obs(d);
    string p = (d == 0) ? "d0_rst_" : "d1_rst_";
    check({p, "in_ready"}, o.in_ready, 0);
    check({p, "mem_we"}, o.mem_we, 0);
    check({p, "mem_oe"}, o.mem_oe, 0);
    check({p, "mem_cs"}, o.mem_cs, 1);
    check({p, "mem_addr"}, o.mem_addr, 0);
    check({p, "mem_wdata"}, o.mem_wdata, 0);
    check({p, "words_loaded"}, o.words, 0);
    check({p, "on_bios"}, o.on_bios, 0);
    check({p, "pipe_enable"}, o.pipe, 0);
    check({p, "done"}, o.done, 0);
    check({p, "error"}, o.error, 0);
  endtask

  // Reference model: a header N in 1..MAX_WORDS produces N writes at BASE+i (mod 2^32),
  // one done pulse and RUN; anything else ends in ERROR right after the header.
  task automatic run_load(input int d, input logic [31:0] hdr, input wq_t w, input bit gaps);
    int   lanes = lanes_of(d);
    bit   ok_len = (hdr != 0) && (hdr <= MAX_WORDS);
    bq_t  b;
    int   c1, lat, done_before, stall_before;
    obs_t o;
    add_bytes(b, hdr, lanes);
    if (ok_len) begin
      for (int i = 0; i < int'(hdr); i++) begin
        add_bytes(b, w[i], lanes);
        push_exp(d, base_of(d) + 32'(i), w[i]);
      end
    end
    done_before  = (d == 0) ? done_cnt0 : done_cnt1;
    stall_before = (d == 0) ? stall_cnt0 : stall_cnt1;
    pulse_start(d);
    c1 = cyc;
    o = obs(d);
    check("hdr_entry_on_bios_pipe_ready", {o.on_bios, o.pipe, o.in_ready}, 3'b101);
    stream(d, b, gaps);
    if (ok_len) begin
      wait_done(d, lat);
      check("done_latency_after_last_byte", lat, 2);
      if (!gaps) check("load_cycles", cyc - c1, lanes + int'(hdr) * (lanes + 1));
      o = obs(d);
      check("run_pipe_enable", o.pipe, 1);
      check("run_words_loaded", o.words, hdr);
      check("run_on_bios_error", {o.on_bios, o.error}, 2'b00);
      check("run_cs_oe_we", {o.mem_cs, o.mem_oe, o.mem_we}, 3'b010);
      check("write_cycle_stalls", ((d == 0) ? stall_cnt0 : stall_cnt1) - stall_before, hdr);
      @(negedge clock);
      check("done_one_cycle", obs(d).done, 0);
      check("done_pulse_count", ((d == 0) ? done_cnt0 : done_cnt1) - done_before, 1);
      @(posedge clock); #1;
    end else begin
      o = obs(d);
      check("badlen_error", o.error, 1);
      check("badlen_on_bios_pipe_ready", {o.on_bios, o.pipe, o.in_ready}, 3'b000);
    end
    check("pending_writes", pending(d), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wq_t w;
    wq_t none;
    bq_t b;
    int  n;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; pc0 = '0; pc1 = '0;
    set_in(0, 1'b0, 8'h00); set_in(1, 1'b0, 8'h00);
    repeat (3) @(posedge clock);
    #1;
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // Nominal 32-bit load, then memory address follows the PC in RUN.
    w = {32'h44332211, 32'h88776655, 32'hCCBBAA99};
    run_load(0, 3, w, 1'b0);
    pc0 = 32'd5; #1;
    check("d0_run_mem_addr_pc5", obs(0).mem_addr, 5);
    pc0 = $urandom; #1;
    check("d0_run_mem_addr_pc_rand", obs(0).mem_addr, pc0);

    // Reload from RUN with a single word.
    w = {$urandom};
    run_load(0, 1, w, 1'b0);

    // Bad lengths: zero and one past the maximum (second one starts from ERROR).
    run_load(0, 0, none, 1'b0);
    run_load(0, MAX_WORDS + 1, none, 1'b0);

    // Randomized loads with idle gaps.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_load(0, n, w, 1'b1);
    end

    // Continuous in_valid: WRITE cycles must stall the source without losing bytes.
    w = {};
    for (int i = 0; i < 4; i++) w.push_back($urandom);
    run_load(0, 4, w, 1'b0);

    // Stall timeout two bytes into word 1.
    w = {$urandom, $urandom};
    b = {};
    add_bytes(b, 32'd3, 4);
    add_bytes(b, w[0], 4);
    b.push_back(w[1][7:0]);
    b.push_back(w[1][15:8]);
    push_exp(0, 32'h0, w[0]);
    pulse_start(0);
    stream(0, b, 1'b0);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (obs(0).error) begin n = c; break; end
    end
    check("d0_timeout_cycles", n, 16);
    check("d0_timeout_words_loaded", obs(0).words, 1);
    check("d0_timeout_on_bios_ready", {obs(0).on_bios, obs(0).in_ready}, 2'b00);
    check("d0_timeout_pending", pending(0), 0);

    // Asynchronous reset during the WRITE of word 2.
    w = {};
    for (int i = 0; i < 4; i++) w.push_back($urandom);
    b = {};
    add_bytes(b, 32'd4, 4);
    for (int i = 0; i < 3; i++) add_bytes(b, w[i], 4);
    push_exp(0, 32'h0, w[0]);
    push_exp(0, 32'h1, w[1]);
    pulse_start(0);
    stream(0, b, 1'b0);
    check("d0_in_write_before_reset", obs(0).mem_we, 1);
    rst_n = 1'b0; #1;
    check_reset(0);
    check("d0_reset_pending", pending(0), 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    w = {$urandom, $urandom};
    run_load(0, 2, w, 1'b1);

    // 16-bit variant: pairs pack little-endian; addresses wrap past 0xFFFF_FFFF.
    w = {32'h2211, 32'h4433, 32'h6655};
    run_load(1, 3, w, 1'b0);
    run_load(1, 0, none, 1'b0);
    w = {};
    for (int i = 0; i < MAX_WORDS; i++) w.push_back($urandom_range(0, 16'hFFFF));
    run_load(1, MAX_WORDS, w, 1'b1);
    pc1 = $urandom; #1;
    check("d1_run_mem_addr_pc", obs(1).mem_addr, pc1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Parametrised successor of the top-level BIOS load sequencing; owns power-up program loading.
- Receives a length-prefixed byte stream over a valid/ready handshake and packs bytes into little-endian words.
- Writes each word into instruction memory, then hands the memory address port to the program counter and releases the pipeline.
- Adds the following, which the current fixed-time BIOS window does not have: configurable word width and memory depth, a length header, backpressure, a stall timeout, an error state and restart.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, instruction memory address width.
- BASE_ADDR, 0, first instruction-memory word address written.
- MAX_WORDS, 256, largest accepted program length in words.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes while loading.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE, RUN and ERROR.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  sequencer accepts a byte this cycle.
- pc_addr  in  ADDR_WIDTH  program counter output, used in RUN.
- mem_addr  out  ADDR_WIDTH  instruction memory address.
- mem_wdata  out  DATA_WIDTH  instruction memory write data.
- mem_cs  out  1  chip select, active-low, matching the memory model.
- mem_we  out  1  write enable.
- mem_oe  out  1  output enable.
- on_bios  out  1  high while loading (HEADER, LOAD, WRITE).
- pipe_enable  out  1  PC and pipeline-register enable.
- words_loaded  out  ADDR_WIDTH  count of words written this load.
- done  out  1  one-cycle pulse on entry to RUN.
- error  out  1  high while in ERROR.

Behaviour:
- Word geometry: L = DATA_WIDTH/8 byte lanes.
- Byte transfer: occurs when in_valid and in_ready are both high at a rising edge.
- Byte order: byte k of a word lands in bits [8k+7:8k], little-endian.
- Lane counter: wraps from L-1 to 0.
- Reset (asynchronous, reset=0), all registered outputs cleared:
  - state = IDLE, in_ready = 0, mem_we = 0, mem_oe = 0, mem_cs = 1.
  - mem_addr = 0, mem_wdata = 0, words_loaded = 0.
  - on_bios = 0, pipe_enable = 0, done = 0, error = 0.
  - Lane counter, length register and timeout counter cleared.
- Reset mid-load abandons the load; memory contents already written are left as they are.
- States:
  - IDLE: start -> HEADER.
  - HEADER:
    - in_ready = 1; assembles L bytes into length N.
    - On the final byte: N == 0 or N > MAX_WORDS -> ERROR; otherwise -> LOAD with words_loaded = 0.
  - LOAD:
    - in_ready = 1; assembles L bytes.
    - The final-byte transfer latches mem_wdata and mem_addr = BASE_ADDR + words_loaded, then -> WRITE.
  - WRITE:
    - Exactly one cycle: mem_cs = 0, mem_we = 1, mem_oe = 0, in_ready = 0.
    - Next edge: words_loaded increments. If the new count equals N -> RUN, otherwise -> LOAD.
  - RUN:
    - mem_addr = pc_addr (combinational pass-through), mem_cs = 0, mem_oe = 1, mem_we = 0.
    - pipe_enable = 1; done is high for the first RUN cycle only.
    - start -> HEADER: pipe_enable drops on the next cycle and the lane counter is cleared.
  - ERROR:
    - error = 1, pipe_enable = 0, in_ready = 0.
    - start -> HEADER; only reset otherwise exits.
- Timeout:
  - In HEADER or LOAD the counter increments each cycle with no transfer and clears on every transfer.
  - On reaching TIMEOUT_CYCLES -> ERROR, including partway through a word.
- Backpressure: in_ready is registered low in the WRITE cycle; bytes presented then are held by the source, not dropped.
- Throughput: one word per L+1 cycles at full in_valid rate.
- Widths:
  - words_loaded saturates at N and never exceeds MAX_WORDS.
  - Address addition is modulo 2^ADDR_WIDTH.
- Simultaneous events: a start that coincides with the last HEADER/LOAD byte is ignored.
- on_bios = 1 exactly in HEADER, LOAD and WRITE.

Test Plan:
- Nominal load, DATA_WIDTH = 32, BASE_ADDR = 0:
  - Stimulus: header bytes 03 00 00 00, then 12 instructions bytes (11 22 33 44, ...).
  - Response: three mem_we pulses at addresses 0, 1, 2; word 0 = 0x44332211; done pulses once; pipe_enable = 1; mem_addr follows pc_addr = 5.
- Bad length:
  - Stimulus: header N = 0 on one run; N = MAX_WORDS + 1 = 257 on another.
  - Response: ERROR after the 4th byte; error = 1; no mem_we pulse.
- Stall timeout:
  - Stimulus: TIMEOUT_CYCLES = 16; stop in_valid after 2 bytes of word 1.
  - Response: ERROR exactly 16 cycles after the last transfer; words_loaded = 1.
- Backpressure:
  - Stimulus: hold in_valid high continuously with N = 4.
  - Response: in_ready is low every 5th cycle; no byte is lost; all 4 words are correct.
- Async reset mid-load:
  - Stimulus: drop reset during WRITE of word 2.
  - Response: all outputs immediately take their reset values; state is IDLE; a subsequent start reloads cleanly.
- Reload and width variant:
  - Stimulus: start in RUN, then reload N = 1; also repeat the nominal load with DATA_WIDTH = 16.
  - Response: pipe_enable drops during the reload and done pulses again. With DATA_WIDTH = 16, byte pairs pack to 0x2211.
